hdsiso_lfsr_checker: RTL and testbench
======================================

// Module: hdsiso_lfsr_checker
// PURPOSE
//  Receive-side checker for the HDSISO8 serial-in/serial-out delay chain.
//  Consumes the serial bit stream leaving the chain and self-seeds a Fibonacci LFSR
//  reference from it, then locks and counts bit mismatches against the predicted sequence.
//  Sits inside tt_um_ygdes_hdsiso8 between the chain output and uo_out status bits.
// PARAMETERS
//  LFSR_W   8      reference LFSR width, 2..16
//  TAPS     8'hB8  feedback tap mask, LFSR_W bits, bit i set = state[i] feeds XOR
//  LOCK_CNT 16     consecutive matches needed in VERIFY before LOCKED, 1..255
//  LOST_TH  4      consecutive mismatches in LOCKED that drop lock, 1..15
//  ERR_W    8      error counter width
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst_n      in   1      synchronous active-low reset
//  ena        in   1      design enable; 0 = hold all state, ignore sin_valid
//  sin_valid  in   1      one received bit present on sin_data this cycle
//  sin_data   in   1      received serial bit
//  clr_cnt    in   1      synchronous clear of err_cnt, no state change
//  locked     out  1      1 while in LOCKED
//  err_cnt    out  ERR_W  saturating mismatch count, LOCKED state only
//  err_pulse  out  1      1-cycle pulse per counted mismatch
//  lost_lock  out  1      1-cycle pulse on LOCKED -> SEED
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=SEED, ref=0, bitcnt=0, runcnt=0,
//    locked=0, err_cnt=0, err_pulse=0, lost_lock=0. Reset overrides everything.
//  - A bit is consumed only on cycles with ena=1 && sin_valid=1; otherwise all
//    registers hold and the pulse outputs are 0 the next cycle.
//  - pred = ^(ref & TAPS); shift = {ref[LFSR_W-2:0], x}. Outputs are registered,
//    so a result appears 1 cycle after the bit is consumed.
//  - SEED: ref <= shift with x=sin_data; bitcnt++. After LFSR_W bits go VERIFY,
//    except when the resulting ref is all-zero: stay SEED, bitcnt=0.
//  - VERIFY: sin_data==pred -> ref<=shift(pred), runcnt++; when runcnt reaches
//    LOCK_CNT go LOCKED, runcnt=0. On mismatch go SEED, bitcnt=0, ref kept,
//    no err_pulse, err_cnt unchanged.
//  - LOCKED: ref <= shift(pred) always (free-running, errors never propagate).
//    Mismatch: err_pulse=1, err_cnt++ (saturates at all-ones), miss++.
//    Match: miss=0. When miss reaches LOST_TH: go SEED, lost_lock=1, bitcnt=0,
//    miss=0, locked=0 in the same cycle as lost_lock.
//  - clr_cnt: err_cnt <= 0. If an increment occurs in the same cycle, the
//    clear wins and err_cnt=0. err_pulse still fires.
//  - err_cnt is never cleared by lock loss, only by reset or clr_cnt.
//  - State encoding: SEED=2'd0, VERIFY=2'd1, LOCKED=2'd2. 2'd3 is illegal and
//    goes to SEED on the next edge.
// STRUCTURE
//  - Shared package hdsiso_pkg: state enum/localparams (SEED/VERIFY/LOCKED),
//    default TAPS constant, and the LFSR next-bit function.
//  - One sub-module: hdsiso_lfsr_ref, which holds ref plus the load/advance
//    controls and exports pred.
//  - FSM, counters and outputs stay in this module.
// TESTING
//  1. Reset, then feed the clean TAPS=B8 LFSR stream seeded 8'h01.
//     -> locked=1 exactly 1 cycle after bit 8+16=24; err_cnt=0.
//  2. Locked, flip one bit at bit 40.
//     -> err_pulse 1 cycle later, err_cnt=1, locked stays 1.
//  3. Locked, flip 4 consecutive bits.
//     -> err_cnt=4, lost_lock pulse on 4th, locked=0.
//     Clean stream resumes -> relock 24 bits later; err_cnt stays 4.
//  4. 8 zero bits, then all-zero input.
//     -> stays SEED forever, locked=0.
//     Then a valid stream -> locks.
//  5. ERR_W=8 with continuous errors (keep miss<LOST_TH by alternating).
//     -> err_cnt saturates at 255. clr_cnt coincident with a mismatch -> err_cnt=0.
//  6. ena=0 / sin_valid gaps mid-stream, plus rst_n=0 mid-LOCKED.
//     -> gaps change nothing.
//     Reset -> all outputs 0 next cycle, SEED.

Source files
------------

// File: rtl/hdsiso_pkg.sv
// Shared definitions for the HDSISO8 receive-side checker.
//   state_t        : checker FSM states (SEED / VERIFY / LOCKED); 2'd3 is unused
//   DEFAULT_TAPS   : default Fibonacci feedback tap mask for the 8-bit reference
//   lfsr_next_bit  : predicted next bit of a Fibonacci LFSR, XOR of tapped bits
package hdsiso_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

    // Operands are zero-extended to 16 bits so any width 2..16 can share it.
    function automatic logic lfsr_next_bit(input logic [15:0] state, input logic [15:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/hdsiso_lfsr_checker_if.sv
// Bundle of the checker's stream input, control and status signals.
//   ena, sin_valid, sin_data, clr_cnt : driven by the master (stream source)
//   locked, err_cnt, err_pulse, lost_lock : driven by the slave (checker)
interface hdsiso_lfsr_checker_if #(
    parameter int ERR_W = 8
);
    logic             ena;
    logic             sin_valid;
    logic             sin_data;
    logic             clr_cnt;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic             err_pulse;
    logic             lost_lock;

    modport master (
        output ena, sin_valid, sin_data, clr_cnt,
        input  locked, err_cnt, err_pulse, lost_lock
    );

    modport slave (
        input  ena, sin_valid, sin_data, clr_cnt,
        output locked, err_cnt, err_pulse, lost_lock
    );
endinterface

// File: rtl/hdsiso_lfsr_ref.sv
// Reference Fibonacci LFSR for the checker.
//   clk, rst_n : clock, synchronous active-low reset (clears the register)
//   load       : shift din in (seeding from the received stream)
//   advance    : shift the register's own prediction in (free-running)
//   din        : received bit used by load
//   pred       : predicted next stream bit from the current register
//   load_zero  : the register would be all-zero after a load of din
module hdsiso_lfsr_ref
    import hdsiso_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic advance,
    input  logic din,
    output logic pred,
    output logic load_zero
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;

    assign pred      = lfsr_next_bit(16'(lfsr_reg), 16'(TAPS));
    assign load_zero = ({lfsr_reg[LFSR_W-2:0], din} == '0);

    always_comb begin
        lfsr_next = lfsr_reg;
        if (load) begin
            lfsr_next = {lfsr_reg[LFSR_W-2:0], din};
        end else if (advance) begin
            lfsr_next = {lfsr_reg[LFSR_W-2:0], pred};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg <= '0;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

endmodule

// File: rtl/hdsiso_lfsr_checker.sv
// Receive-side checker for the HDSISO8 serial delay chain.
// Seeds a reference LFSR from the incoming stream, verifies it against a run of
// predicted bits, then locks and counts mismatches against the prediction.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of hdsiso_lfsr_checker_if
//            in : ena, sin_valid, sin_data, clr_cnt
//            out: locked, err_cnt (saturating), err_pulse, lost_lock
// All outputs are registered: the effect of a consumed bit shows one cycle later.
module hdsiso_lfsr_checker
    import hdsiso_pkg::*;
#(
    parameter int                LFSR_W   = 8,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(DEFAULT_TAPS),
    parameter int                LOCK_CNT = 16,
    parameter int                LOST_TH  = 4,
    parameter int                ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hdsiso_lfsr_checker_if.slave bus
);

    localparam logic [4:0] BIT_LAST  = 5'(LFSR_W - 1);
    localparam logic [7:0] RUN_LAST  = 8'(LOCK_CNT - 1);
    localparam logic [3:0] MISS_LAST = 4'(LOST_TH - 1);

    state_t           state_reg;
    logic [4:0]       bitcnt_reg;
    logic [7:0]       runcnt_reg;
    logic [3:0]       miss_reg;
    logic             locked_reg;
    logic [ERR_W-1:0] err_cnt_reg;
    logic             err_pulse_reg;
    logic             lost_lock_reg;

    logic consume;
    logic pred;
    logic load_zero;
    logic bit_match;
    logic ref_load;
    logic ref_advance;
    logic err_inc;

    assign consume   = bus.ena & bus.sin_valid;
    assign bit_match = (bus.sin_data == pred);

    // Seeding shifts the received bit in; once verified or locked the reference
    // only ever shifts its own prediction, so a corrupted bit never enters it.
    assign ref_load    = consume && (state_reg == ST_SEED);
    assign ref_advance = consume && ((state_reg == ST_LOCKED) ||
                                     (state_reg == ST_VERIFY && bit_match));
    assign err_inc     = consume && (state_reg == ST_LOCKED) && !bit_match;

    hdsiso_lfsr_ref #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_ref (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ref_load),
        .advance   (ref_advance),
        .din       (bus.sin_data),
        .pred      (pred),
        .load_zero (load_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_SEED;
            bitcnt_reg    <= '0;
            runcnt_reg    <= '0;
            miss_reg      <= '0;
            locked_reg    <= 1'b0;
            err_cnt_reg   <= '0;
            err_pulse_reg <= 1'b0;
            lost_lock_reg <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            lost_lock_reg <= 1'b0;

            case (state_reg)
                ST_SEED: begin
                    if (consume) begin
                        if (bitcnt_reg == BIT_LAST) begin
                            bitcnt_reg <= '0;
                            // An all-zero seed is the LFSR lock-up state; keep seeding.
                            if (!load_zero) begin
                                state_reg  <= ST_VERIFY;
                                runcnt_reg <= '0;
                            end
                        end else begin
                            bitcnt_reg <= bitcnt_reg + 5'd1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (consume) begin
                        if (bit_match) begin
                            if (runcnt_reg == RUN_LAST) begin
                                state_reg  <= ST_LOCKED;
                                locked_reg <= 1'b1;
                                runcnt_reg <= '0;
                                miss_reg   <= '0;
                            end else begin
                                runcnt_reg <= runcnt_reg + 8'd1;
                            end
                        end else begin
                            state_reg  <= ST_SEED;
                            bitcnt_reg <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (consume) begin
                        if (!bit_match) begin
                            err_pulse_reg <= 1'b1;
                            if (miss_reg == MISS_LAST) begin
                                state_reg     <= ST_SEED;
                                lost_lock_reg <= 1'b1;
                                locked_reg    <= 1'b0;
                                bitcnt_reg    <= '0;
                                miss_reg      <= '0;
                            end else begin
                                miss_reg <= miss_reg + 4'd1;
                            end
                        end else begin
                            miss_reg <= '0;
                        end
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean seeding state.
                    state_reg  <= ST_SEED;
                    bitcnt_reg <= '0;
                    locked_reg <= 1'b0;
                end
            endcase

            // Clear takes priority over a coincident increment.
            if (bus.ena && bus.clr_cnt) begin
                err_cnt_reg <= '0;
            end else if (err_inc && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err_cnt   = err_cnt_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.lost_lock = lost_lock_reg;

endmodule

// File: tb/tb_hdsiso_lfsr_checker.sv
// Self-checking bench for hdsiso_lfsr_checker: randomized gaps and errors on a
// TAPS=B8 LFSR stream, a queue-based behavioural model compared every cycle,
// and literal expectations at the key points of each scenario.
module tb_hdsiso_lfsr_checker;

    localparam int W       = 8;
    localparam int LOCK_N  = 16;
    localparam int LOST_N  = 4;
    localparam int ERR_MAX = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hdsiso_lfsr_checker_if #(.ERR_W(8)) bus ();

    hdsiso_lfsr_checker #(
        .LFSR_W   (W),
        .TAPS     (8'hB8),
        .LOCK_CNT (LOCK_N),
        .LOST_TH  (LOST_N),
        .ERR_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // hist holds the last W bits the reference has absorbed, newest at the back;
    // tap i refers to the bit absorbed i steps before the newest.
    logic [7:0] taps_v = 8'hB8;
    bit   hist[$];
    int   m_mode;      // 0 seeding, 1 verifying, 2 locked
    int   m_bits, m_run, m_miss, m_err;
    bit   m_locked, m_pulse, m_lost;

    function automatic bit m_pred();
        bit p = 0;
        for (int i = 0; i < W; i++)
            if (taps_v[i]) p ^= hist[W-1-i];
        return p;
    endfunction

    function automatic void m_absorb(input bit x);
        void'(hist.pop_front());
        hist.push_back(x);
    endfunction

    function automatic bit m_all_zero();
        foreach (hist[i]) if (hist[i]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < W; i++) hist.push_back(1'b0);
            m_mode = 0; m_bits = 0; m_run = 0; m_miss = 0; m_err = 0;
            m_locked = 0; m_pulse = 0; m_lost = 0;
        end else begin
            bit d, p;
            m_pulse = 0;
            m_lost  = 0;
            d = bus.sin_data;
            p = m_pred();
            if (bus.ena && bus.sin_valid) begin
                if (m_mode == 0) begin
                    m_absorb(d);
                    m_bits++;
                    if (m_bits == W) begin
                        m_bits = 0;
                        if (!m_all_zero()) begin m_mode = 1; m_run = 0; end
                    end
                end else if (m_mode == 1) begin
                    if (d == p) begin
                        m_absorb(p);
                        m_run++;
                        if (m_run == LOCK_N) begin
                            m_mode = 2; m_run = 0; m_miss = 0; m_locked = 1;
                        end
                    end else begin
                        m_mode = 0; m_bits = 0;
                    end
                end else begin
                    m_absorb(p);
                    if (d != p) begin
                        m_pulse = 1;
                        if (m_err < ERR_MAX) m_err++;
                        m_miss++;
                        if (m_miss == LOST_N) begin
                            m_mode = 0; m_lost = 1; m_locked = 0; m_bits = 0; m_miss = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            end
            if (bus.ena && bus.clr_cnt) m_err = 0;
        end
    end

    // Compare every cycle once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            check("cyc_locked",    int'(bus.locked),    int'(m_locked));
            check("cyc_err_cnt",   int'(bus.err_cnt),   m_err);
            check("cyc_err_pulse", int'(bus.err_pulse), int'(m_pulse));
            check("cyc_lost_lock", int'(bus.lost_lock), int'(m_lost));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] g;   // source LFSR, same polynomial as the reference

    function automatic bit gen_bit();
        bit x = ^(g & 8'hB8);
        g = {g[6:0], x};
        return x;
    endfunction

    task automatic tick(input bit e, input bit v, input bit d, input bit c);
        bus.ena = e; bus.sin_valid = v; bus.sin_data = d; bus.clr_cnt = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gap();
        if ($urandom_range(0, 1) == 0) tick(1'b0, 1'b1, 1'($urandom), 1'b0);
        else                           tick(1'b1, 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic send(input bit d, input bit c);
        if ($urandom_range(0, 3) == 0) gap();
        tick(1'b1, 1'b1, d, c);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(gen_bit(), 1'b0);
    endtask

    task automatic send_flip();
        send(~gen_bit(), 1'b0);
    endtask

    initial begin
        bus.ena = 0; bus.sin_valid = 0; bus.sin_data = 0; bus.clr_cnt = 0;
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        armed = 1;
        check("rst_locked",    int'(bus.locked),    0);
        check("rst_err_cnt",   int'(bus.err_cnt),   0);
        check("rst_err_pulse", int'(bus.err_pulse), 0);
        check("rst_lost_lock", int'(bus.lost_lock), 0);
        rst_n = 1;

        // 1: clean stream seeded 8'h01 locks right after bit 24
        g = 8'h01;
        send_clean(23);
        check("t1_not_yet_locked", int'(bus.locked), 0);
        send_clean(1);
        check("t1_locked", int'(bus.locked), 1);
        check("t1_model_locked", int'(m_locked), 1);
        check("t1_err_cnt", int'(bus.err_cnt), 0);

        // 2: single flipped bit at bit 40
        send_clean(15);
        send_flip();
        check("t2_err_pulse", int'(bus.err_pulse), 1);
        check("t2_err_cnt", int'(bus.err_cnt), 1);
        check("t2_locked", int'(bus.locked), 1);
        send_clean($urandom_range(5, 20));
        check("t2_pulse_gone", int'(bus.err_pulse), 0);

        // 3: four consecutive flips drop lock, clean stream relocks
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_cleared", int'(bus.err_cnt), 0);
        send_clean($urandom_range(5, 20));
        for (int i = 0; i < 3; i++) send_flip();
        check("t3_still_locked", int'(bus.locked), 1);
        check("t3_no_lost_yet", int'(bus.lost_lock), 0);
        send_flip();
        check("t3_lost_lock", int'(bus.lost_lock), 1);
        check("t3_unlocked", int'(bus.locked), 0);
        check("t3_err_cnt", int'(bus.err_cnt), 4);
        send_clean(23);
        check("t3_not_relocked", int'(bus.locked), 0);
        send_clean(1);
        check("t3_relocked", int'(bus.locked), 1);
        check("t3_err_kept", int'(bus.err_cnt), 4);

        // 4: all-zero input never leaves seeding, then a real stream locks
        rst_n = 0;
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1;
        for (int i = 0; i < 40; i++) send(1'b0, 1'b0);
        check("t4_zero_unlocked", int'(bus.locked), 0);
        g = 8'h01;
        send_clean(23);
        check("t4_not_yet", int'(bus.locked), 0);
        send_clean(1);
        check("t4_locked", int'(bus.locked), 1);

        // 5: alternating errors saturate the counter; clear beats an increment
        for (int i = 0; i < 260; i++) begin
            send_flip();
            send_clean(1);
        end
        check("t5_saturated", int'(bus.err_cnt), 255);
        check("t5_still_locked", int'(bus.locked), 1);
        send(~gen_bit(), 1'b1);
        check("t5_clear_wins", int'(bus.err_cnt), 0);
        check("t5_pulse_with_clear", int'(bus.err_pulse), 1);
        send_clean(1);

        // 6: gaps change nothing; reset mid-lock clears everything
        for (int i = 0; i < 6; i++) gap();
        check("t6_gap_locked", int'(bus.locked), 1);
        check("t6_gap_err", int'(bus.err_cnt), 0);
        send_flip();
        send_clean(3);
        rst_n = 0;
        tick(1'b1, 1'b1, 1'($urandom), 1'b0);
        check("t6_rst_locked", int'(bus.locked), 0);
        check("t6_rst_err_cnt", int'(bus.err_cnt), 0);
        check("t6_rst_err_pulse", int'(bus.err_pulse), 0);
        check("t6_rst_lost_lock", int'(bus.lost_lock), 0);
        rst_n = 1;
        send_clean(23);
        check("t6_not_yet", int'(bus.locked), 0);
        send_clean(1);
        check("t6_relocked", int'(bus.locked), 1);

        // Random soak: sparse errors, occasional clears, model-checked each cycle
        for (int i = 0; i < 400; i++) begin
            bit b = gen_bit();
            if ($urandom_range(0, 7) == 0) b = ~b;
            send(b, ($urandom_range(0, 31) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
